// File: rtl/gate_motor_driver.sv
// Gate motor driver: turns open/close commands into exclusive forward/reverse
// drives with limit stops, reversal dead time, obstacle reversal and a travel watchdog.
module gate_motor_driver #(
  parameter int TRAVEL_TIMEOUT = 1000,
  parameter int DEAD_CYCLES    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic gate_open,
  input  logic gate_close,
  input  logic limit_open,
  input  logic limit_closed,
  input  logic obstacle,
  output logic motor_fwd,
  output logic motor_rev,
  output logic at_open,
  output logic at_closed,
  output logic fault
);

  localparam int TW = $clog2(TRAVEL_TIMEOUT + 1);
  localparam int DW = $clog2(DEAD_CYCLES + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TRAVEL_TIMEOUT - 1);
  localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_OPENING = 3'd1;
  localparam logic [2:0] S_OPEN    = 3'd2;
  localparam logic [2:0] S_CLOSING = 3'd3;
  localparam logic [2:0] S_CLOSED  = 3'd4;
  localparam logic [2:0] S_DEAD    = 3'd5;
  localparam logic [2:0] S_FAULT   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] dead_q, dead_d;
  // Direction to take once the dead time expires: 1 = opening, 0 = closing.
  logic          pend_open_q, pend_open_d;

  logic open_req, close_req;

  assign open_req  = gate_open & ~gate_close;
  assign close_req = gate_close & ~gate_open;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    dead_d      = dead_q;
    pend_open_d = pend_open_q;
    if ((state_q != S_FAULT) && limit_open && limit_closed) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (open_req) begin
            if (limit_open) begin
              state_d = S_OPEN;
            end else begin
              state_d = S_OPENING;
              timer_d = '0;
            end
          end else if (close_req) begin
            if (limit_closed) begin
              state_d = S_CLOSED;
            end else begin
              state_d = S_CLOSING;
              timer_d = '0;
            end
          end
        end
        S_OPENING: begin
          if (limit_open) begin
            state_d = S_OPEN;
          end else if (close_req) begin
            state_d     = S_DEAD;
            dead_d      = '0;
            pend_open_d = 1'b0;
          end else if (timer_q == TIMER_LAST) begin
            state_d = S_FAULT;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_CLOSING: begin
          if (limit_closed) begin
            state_d = S_CLOSED;
          end else if (obstacle || open_req) begin
            state_d     = S_DEAD;
            dead_d      = '0;
            pend_open_d = 1'b1;
          end else if (timer_q == TIMER_LAST) begin
            state_d = S_FAULT;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_OPEN: begin
          // A close request while blocked is dropped, not remembered.
          if (close_req && !obstacle) begin
            state_d = S_CLOSING;
            timer_d = '0;
          end
        end
        S_CLOSED: begin
          if (open_req) begin
            state_d = S_OPENING;
            timer_d = '0;
          end
        end
        S_DEAD: begin
          if (dead_q == DEAD_LAST) begin
            state_d = pend_open_q ? S_OPENING : S_CLOSING;
            timer_d = '0;
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      dead_q      <= '0;
      pend_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      dead_q      <= dead_d;
      pend_open_q <= pend_open_d;
    end
  end

  assign motor_fwd = (state_q == S_OPENING);
  assign motor_rev = (state_q == S_CLOSING);
  assign at_open   = (state_q == S_OPEN);
  assign at_closed = (state_q == S_CLOSED);
  assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_gate_motor_driver.sv
// Directed bench for gate_motor_driver with TRAVEL_TIMEOUT=16, DEAD_CYCLES=4.
// Output vector order: {motor_fwd, motor_rev, at_open, at_closed, fault}.
module tb_gate_motor_driver;

  logic clk = 1'b0;
  logic reset, gate_open, gate_close, limit_open, limit_closed, obstacle;
  logic motor_fwd, motor_rev, at_open, at_closed, fault;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] O_NONE   = 5'b00000;
  localparam logic [4:0] O_FWD    = 5'b10000;
  localparam logic [4:0] O_REV    = 5'b01000;
  localparam logic [4:0] O_OPEN   = 5'b00100;
  localparam logic [4:0] O_CLOSED = 5'b00010;
  localparam logic [4:0] O_FAULT  = 5'b00001;

  gate_motor_driver #(.TRAVEL_TIMEOUT(16), .DEAD_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .gate_open(gate_open), .gate_close(gate_close),
    .limit_open(limit_open), .limit_closed(limit_closed), .obstacle(obstacle),
    .motor_fwd(motor_fwd), .motor_rev(motor_rev),
    .at_open(at_open), .at_closed(at_closed), .fault(fault)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {motor_fwd, motor_rev, at_open, at_closed, fault};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; gate_open = 1'b0; gate_close = 1'b0;
    limit_open = 1'b0; limit_closed = 1'b0; obstacle = 1'b0;
    tick();
    tick();
    chk("reset", O_NONE);
    reset = 1'b0;

    // Conflicting commands in IDLE
    gate_open = 1'b1; gate_close = 1'b1;
    tick(); chk("conflict_1", O_NONE);
    tick(); chk("conflict_2", O_NONE);
    gate_open = 1'b0; gate_close = 1'b0;

    // Open with a one-cycle pulse, limit after 10 drive cycles
    gate_open = 1'b1;
    tick(); chk("open_start", O_FWD);
    gate_open = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick(); chk("opening", O_FWD);
    end
    limit_open = 1'b1;
    tick(); chk("open_limit", O_OPEN);

    // Blocked close is dropped
    obstacle = 1'b1; gate_close = 1'b1;
    tick(); chk("blocked_close", O_OPEN);
    gate_close = 1'b0;
    tick(); chk("blocked_hold", O_OPEN);
    obstacle = 1'b0;
    tick(); chk("blocked_dropped", O_OPEN);

    // Close, obstacle after 5 drive cycles, dead time, reopen
    gate_close = 1'b1;
    tick(); chk("close_start", O_REV);
    gate_close = 1'b0; limit_open = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("closing", O_REV);
    end
    obstacle = 1'b1;
    tick(); chk("dead_1", O_NONE);
    gate_close = 1'b1;
    tick(); chk("dead_2", O_NONE);
    gate_close = 1'b0;
    tick(); chk("dead_3", O_NONE);
    tick(); chk("dead_4", O_NONE);
    tick(); chk("reversed_fwd", O_FWD);
    obstacle = 1'b0; limit_open = 1'b1;
    tick(); chk("reopened", O_OPEN);

    // Close with obstacle and limit_closed together: limit wins
    limit_open = 1'b0; gate_close = 1'b1;
    tick(); chk("close2_start", O_REV);
    gate_close = 1'b0; obstacle = 1'b1; limit_closed = 1'b1;
    tick(); chk("limit_beats_obstacle", O_CLOSED);
    obstacle = 1'b0;
    tick(); chk("closed_hold", O_CLOSED);

    // Timeout: 16 drive cycles then fault
    gate_open = 1'b1;
    tick(); chk("to_start", O_FWD);
    gate_open = 1'b0; limit_closed = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(); chk("to_running", O_FWD);
    end
    tick(); chk("to_fault", O_FAULT);
    gate_open = 1'b1;
    tick(); chk("fault_ign_open", O_FAULT);
    gate_open = 1'b0; gate_close = 1'b1;
    tick(); chk("fault_ign_close", O_FAULT);
    gate_close = 1'b0;
    reset = 1'b1;
    tick(); chk("fault_reset", O_NONE);
    reset = 1'b0;

    // Both limits high while opening
    gate_open = 1'b1;
    tick(); chk("bl_start", O_FWD);
    gate_open = 1'b0;
    tick(); chk("bl_run", O_FWD);
    limit_open = 1'b1; limit_closed = 1'b1;
    tick(); chk("both_limits", O_FAULT);
    limit_open = 1'b0; limit_closed = 1'b0;
    reset = 1'b1;
    tick(); chk("bl_reset", O_NONE);
    reset = 1'b0;

    // Reset in the middle of a reversal
    gate_close = 1'b1;
    tick(); chk("mr_close", O_REV);
    gate_close = 1'b0; gate_open = 1'b1;
    tick(); chk("mr_dead_1", O_NONE);
    gate_open = 1'b0;
    tick(); chk("mr_dead_2", O_NONE);
    reset = 1'b1;
    tick(); chk("mr_reset", O_NONE);
    reset = 1'b0;
    tick(); chk("mr_idle_1", O_NONE);
    tick(); chk("mr_idle_2", O_NONE);
    tick(); chk("mr_idle_3", O_NONE);
    gate_close = 1'b1; limit_closed = 1'b1;
    tick(); chk("mr_to_closed", O_CLOSED);
    gate_close = 1'b0;
    tick(); chk("mr_closed_hold", O_CLOSED);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_motor_driver.md
# gate_motor_driver

Drives the gate actuator from the open/close commands produced by `automatic_gate_controller`, sitting directly downstream of it. Converts `gate_open`/`gate_close` commands into mutually exclusive forward/reverse motor drives, stops on limit switches, and enforces a dead time on every direction reversal. Also provides obstacle auto-reversal while closing, a travel watchdog, and settled-position status back to the system.

## Interface
- `TRAVEL_TIMEOUT`, default 1000: maximum cycles the motor may run in one direction without reaching the matching limit; must be ≥ 2.
- `DEAD_CYCLES`, default 8: cycles both drives are held off on a reversal; must be ≥ 1.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `gate_open` in 1: open command from the gate controller; a level or a single-cycle pulse.
- `gate_close` in 1: close command from the gate controller; a level or a single-cycle pulse.
- `limit_open` in 1: high when the gate is fully open.
- `limit_closed` in 1: high when the gate is fully closed.
- `obstacle` in 1: high while the gate path is blocked.
- `motor_fwd` out 1: opening drive.
- `motor_rev` out 1: closing drive.
- `at_open` out 1: gate settled open.
- `at_closed` out 1: gate settled closed.
- `fault` out 1: latched fault.

## Operation
- Request decode:
  - open_req = `gate_open & ~gate_close`.
  - close_req = `gate_close & ~gate_open`.
  - Both high or both low means no request.
- States: IDLE, OPENING, OPEN, CLOSING, CLOSED, DEAD, FAULT.
- Outputs are Moore-decoded from the registered state:
  - `motor_fwd` = OPENING.
  - `motor_rev` = CLOSING.
  - `at_open` = OPEN.
  - `at_closed` = CLOSED.
  - `fault` = FAULT.
  - `motor_fwd` and `motor_rev` are never both high.
- Global rule: `limit_open & limit_closed` sampled high in any non-FAULT state → FAULT.
- IDLE (position unknown):
  - open_req → OPEN if `limit_open`, else OPENING.
  - close_req → CLOSED if `limit_closed`, else CLOSING.
- OPENING, first matching rule wins:
  1. `limit_open` → OPEN.
  2. close_req → DEAD, pending = CLOSING.
  3. timer = TRAVEL_TIMEOUT-1 → FAULT.
  4. Otherwise stay and increment timer.
- CLOSING, first matching rule wins:
  1. `limit_closed` → CLOSED.
  2. `obstacle` → DEAD, pending = OPENING.
  3. open_req → DEAD, pending = OPENING.
  4. timer = TRAVEL_TIMEOUT-1 → FAULT.
  5. Otherwise stay and increment timer.
- OPEN:
  - close_req with `obstacle` low → CLOSING.
  - close_req with `obstacle` high: stay OPEN. The request is dropped, not queued.
- CLOSED: open_req → OPENING.
- DEAD:
  - Stays exactly DEAD_CYCLES cycles, then enters the pending direction with timer cleared.
  - All commands and `obstacle` are ignored during DEAD.
- FAULT: both drives off; left only by `reset`.
- Timer:
  - Width `$clog2(TRAVEL_TIMEOUT+1)`.
  - Cleared on every entry to OPENING or CLOSING.
  - Never wraps.
- Dead counter: width `$clog2(DEAD_CYCLES+1)`; cleared on entry to DEAD.

## Timing
- Reset (`reset` high at an edge):
  - State becomes IDLE; timer, dead counter and pending direction cleared.
  - All outputs 0 from the cycle after that edge.
  - `reset` mid-motion de-energises the drive after the same edge.
- Command latency: a request sampled at edge N changes the state at edge N, so the drive is asserted in cycle N+1. A 1-cycle pulse is sufficient to start full travel.
- Limit stop: limit sampled at edge N → drive low from cycle N+1.
- Maximum travel: drive high for exactly TRAVEL_TIMEOUT consecutive cycles, then `fault` rises with the drive low in the same cycle.
- Reversal:
  - Last drive cycle, then exactly DEAD_CYCLES cycles with both drives low, then the opposite drive.
  - Minimum gap between opposite drives is DEAD_CYCLES cycles.
- Simultaneous `obstacle` and `limit_closed` while CLOSING: limit wins, giving CLOSED with no reversal.

## Test plan
All scenarios use TRAVEL_TIMEOUT=16 and DEAD_CYCLES=4.

- **Reset, then open:** reset 2 cycles, then a 1-cycle `gate_open` pulse → `motor_fwd`=1 the next cycle. Raise `limit_open` after 10 cycles → `motor_fwd`=0 and `at_open`=1 the following cycle.
- **Close with obstacle:** from OPEN, pulse `gate_close` → `motor_rev`=1. Assert `obstacle` after 5 cycles → `motor_rev`=0, 4 cycles with both drives 0, then `motor_fwd`=1.
- **Timeout fault:** from CLOSED, pulse `gate_open` with no limit → `motor_fwd` high exactly 16 cycles, then `fault`=1. Further commands are ignored until `reset`, which clears all outputs.
- **Conflicting commands / blocked close:**
  - `gate_open`=`gate_close`=1 in IDLE → state stays IDLE, all outputs 0.
  - `gate_close` in OPEN with `obstacle`=1 → remains OPEN.
- **Both limits high:** `limit_open`=`limit_closed`=1 while OPENING → `fault`=1 with both drives 0 the next cycle.
- **Mid-reversal reset:** assert `reset` during DEAD → IDLE with all outputs 0. A following `gate_close` with `limit_closed`=1 → `at_closed`=1 and no drive.
